// File: rtl/lsu_handshake.sv
// Load/store unit bridging the core's valid/ready request port to a req/ack data bus.
// Handles lane placement, byte masks, load extension, misalignment and bus timeout.
module lsu_handshake #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_uext,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              except,
  output logic [1:0]        except_cause,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_wmask,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e          state;
  logic [OW-1:0]   off_q;
  logic [1:0]      size_q;
  logic            uext_q;
  logic [CW-1:0]   cnt;

  logic [OW-1:0]   req_off;
  logic            misaligned;
  logic            illegal;
  logic [15:0]     mask_wide;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext_mask;
  logic [XLEN-1:0] load_data;
  logic            sign;
  int unsigned     ld_width;

  always_comb begin
    req_off    = req_addr[OW-1:0];
    misaligned = (req_off & OW'((1 << req_size) - 1)) != '0;
    illegal    = (req_size == 2'b11) && (XLEN == 32);
    mask_wide  = ((16'd1 << (5'd1 << req_size)) - 16'd1) << req_off;
  end

  // Load path: move the addressed lane down, keep 8*2^size bits, then extend.
  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    ld_width = 8 << size_q;
    if (ld_width >= XLEN) ext_mask = '1;
    else                  ext_mask = (XLEN'(1) << ld_width) - XLEN'(1);
    unique case (size_q)
      2'd0:    sign = shifted[7];
      2'd1:    sign = shifted[15];
      2'd2:    sign = shifted[31];
      default: sign = shifted[XLEN-1];
    endcase
    load_data = (shifted & ext_mask) | ((sign && !uext_q) ? ~ext_mask : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      except       <= 1'b0;
      except_cause <= 2'b00;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wmask    <= '0;
      mem_wdata    <= '0;
      off_q        <= '0;
      size_q       <= 2'b00;
      uext_q       <= 1'b0;
      cnt          <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            off_q     <= req_off;
            size_q    <= req_size;
            uext_q    <= req_uext;
            if (misaligned || illegal) begin
              state        <= StResp;
              resp_valid   <= 1'b1;
              except       <= 1'b1;
              except_cause <= req_we ? 2'b10 : 2'b01;
            end else begin
              state     <= StBus;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[XLEN-1:OW], {OW{1'b0}}};
              mem_wmask <= mask_wide[NB-1:0];
              mem_wdata <= req_wdata << {req_off, 3'b000};
              cnt       <= '0;
            end
          end
        end
        StBus: begin
          if (mem_ack) begin
            state      <= StResp;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= mem_we ? '0 : load_data;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state        <= StResp;
            mem_req      <= 1'b0;
            resp_valid   <= 1'b1;
            except       <= 1'b1;
            except_cause <= 2'b11;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StResp: begin
          state        <= StIdle;
          resp_valid   <= 1'b0;
          resp_rdata   <= '0;
          except       <= 1'b0;
          except_cause <= 2'b00;
          req_ready    <= 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_handshake.sv
// Self-checking bench for lsu_handshake: a 32-bit instance (short timeout) and a 64-bit instance,
// with expected responses queued at issue time and popped when resp_valid appears.
module tb_lsu_handshake;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_we, a_req_uext;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_resp_valid, a_except;
  logic [31:0] a_resp_rdata;
  logic [1:0]  a_except_cause;
  logic        a_mem_req, a_mem_we, a_mem_ack;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_wmask;

  logic        b_req_valid, b_req_ready, b_req_we, b_req_uext;
  logic [1:0]  b_req_size;
  logic [63:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_except;
  logic [63:0] b_resp_rdata;
  logic [1:0]  b_except_cause;
  logic        b_mem_req, b_mem_we, b_mem_ack;
  logic [63:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [7:0]  b_mem_wmask;

  lsu_handshake #(.XLEN(32), .TIMEOUT(4)) u_a (
    .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_size(a_req_size), .req_uext(a_req_uext), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .except(a_except), .except_cause(a_except_cause), .mem_req(a_mem_req), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wmask(a_mem_wmask), .mem_wdata(a_mem_wdata),
    .mem_ack(a_mem_ack), .mem_rdata(a_mem_rdata)
  );

  lsu_handshake #(.XLEN(64), .TIMEOUT(16)) u_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_size(b_req_size), .req_uext(b_req_uext), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .except(b_except), .except_cause(b_except_cause), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wmask(b_mem_wmask), .mem_wdata(b_mem_wdata),
    .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata)
  );

  typedef struct packed {
    logic [63:0] rdata;
    logic        exc;
    logic [1:0]  cause;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic issue_a(input logic we, input logic [1:0] size, input logic uext,
                         input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = we; a_req_size = size; a_req_uext = uext;
    a_req_addr = addr; a_req_wdata = wdata;
    @(posedge clk);
    #1 a_req_valid = 1'b0;
  endtask

  task automatic issue_b(input logic we, input logic [1:0] size, input logic uext,
                         input logic [63:0] addr, input logic [63:0] wdata);
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = we; b_req_size = size; b_req_uext = uext;
    b_req_addr = addr; b_req_wdata = wdata;
    @(posedge clk);
    #1 b_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_req_valid = 0; a_req_we = 0; a_req_size = 0; a_req_uext = 0; a_req_addr = 0; a_req_wdata = 0;
    b_req_valid = 0; b_req_we = 0; b_req_size = 0; b_req_uext = 0; b_req_addr = 0; b_req_wdata = 0;
    a_mem_ack = 1'b1; a_mem_rdata = 32'hFFFF_FFFF; b_mem_ack = 0; b_mem_rdata = 0;
    @(negedge clk);
    n_tests++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready32 got %b want 1", a_req_ready); end
    n_tests++; if (b_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready64 got %b want 1", b_req_ready); end
    n_tests++;
    if ({a_mem_req, a_resp_valid, a_except, a_except_cause, a_mem_we, a_mem_wmask} !== 10'd0) begin
      n_fail++; $display("FAIL rst_outs32 got %b want 0",
                         {a_mem_req, a_resp_valid, a_except, a_except_cause, a_mem_we, a_mem_wmask});
    end
    n_tests++; if ({a_mem_addr, a_mem_wdata, a_resp_rdata} !== 96'd0) begin
      n_fail++; $display("FAIL rst_data32 got %h want 0", {a_mem_addr, a_mem_wdata, a_resp_rdata}); end
    n_tests++; if ({b_mem_req, b_resp_valid, b_mem_wmask} !== 10'd0) begin
      n_fail++; $display("FAIL rst_outs64 got %b want 0", {b_mem_req, b_resp_valid, b_mem_wmask}); end
    reset = 1'b0;
    // Stray ack while idle must not produce a response.
    repeat (2) begin
      @(negedge clk);
      n_tests++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
        n_fail++; $display("FAIL idle_ack got valid=%b ready=%b want 0/1", a_resp_valid, a_req_ready); end
    end
    a_mem_ack = 1'b0;
  endtask

  task automatic test_load32();
    logic [1:0]  t_size[4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic        t_uext[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] t_addr[4] = '{32'h103, 32'h102, 32'h200, 32'h101};
    logic [31:0] t_mrd[4]  = '{32'h80FF_1234, 32'h80FF_1234, 32'hDEAD_BEEF, 32'h0000_9A00};
    logic [31:0] t_maddr[4] = '{32'h100, 32'h100, 32'h200, 32'h100};
    logic [3:0]  t_mask[4] = '{4'b1000, 4'b1100, 4'b1111, 4'b0010};
    logic [31:0] t_exp[4]  = '{32'hFFFF_FF80, 32'h0000_80FF, 32'hDEAD_BEEF, 32'h0000_009A};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue_a(1'b0, t_size[i], t_uext[i], t_addr[i], 32'h0);
      sbq.push_back('{rdata: {32'd0, t_exp[i]}, exc: 1'b0, cause: 2'b00});
      @(negedge clk);
      n_tests++; if (a_mem_req !== 1'b1 || a_mem_we !== 1'b0) begin
        n_fail++; $display("FAIL ld32_req[%0d] got req=%b we=%b want 1/0", i, a_mem_req, a_mem_we); end
      n_tests++; if (a_mem_addr !== t_maddr[i]) begin
        n_fail++; $display("FAIL ld32_addr[%0d] got %h want %h", i, a_mem_addr, t_maddr[i]); end
      n_tests++; if (a_mem_wmask !== t_mask[i]) begin
        n_fail++; $display("FAIL ld32_mask[%0d] got %b want %b", i, a_mem_wmask, t_mask[i]); end
      a_mem_ack = 1'b1; a_mem_rdata = t_mrd[i];
      @(negedge clk);
      a_mem_ack = 1'b0; a_mem_rdata = 32'h5A5A_5A5A;
      n_tests++; if (a_resp_valid !== 1'b1) begin
        n_fail++; $display("FAIL ld32_latency[%0d] got resp_valid=%b want 1", i, a_resp_valid); end
      else if (sbq.size() == 0) begin
        n_fail++; $display("FAIL ld32_sb[%0d] got response with empty queue", i); end
      else begin
        e = sbq.pop_front();
        n_tests++; if ({32'd0, a_resp_rdata} !== e.rdata || a_except !== e.exc) begin
          n_fail++; $display("FAIL ld32_data[%0d] got %h exc=%b want %h exc=%b",
                             i, a_resp_rdata, a_except, e.rdata, e.exc); end
      end
      n_tests++; if (a_req_ready !== 1'b0) begin
        n_fail++; $display("FAIL ld32_busy[%0d] got ready=%b want 0", i, a_req_ready); end
      @(negedge clk);
      n_tests++; if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0 || a_resp_rdata !== 32'd0) begin
        n_fail++; $display("FAIL ld32_idle[%0d] got ready=%b valid=%b rdata=%h want 1/0/0",
                           i, a_req_ready, a_resp_valid, a_resp_rdata); end
    end
  endtask

  task automatic test_store32();
    logic [1:0]  t_size[2]  = '{2'd1, 2'd0};
    logic [31:0] t_addr[2]  = '{32'h22, 32'h1};
    logic [31:0] t_wd[2]    = '{32'h0000_ABCD, 32'h1234_5655};
    logic [31:0] t_expwd[2] = '{32'hABCD_0000, 32'h3456_5500};
    logic [3:0]  t_mask[2]  = '{4'b1100, 4'b0010};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue_a(1'b1, t_size[i], 1'b0, t_addr[i], t_wd[i]);
      sbq.push_back('{rdata: 64'd0, exc: 1'b0, cause: 2'b00});
      for (int d = 0; d < 3; d++) begin
        @(negedge clk);
        n_tests++;
        if (a_mem_req !== 1'b1 || a_mem_we !== 1'b1 || a_mem_wdata !== t_expwd[i] ||
            a_mem_wmask !== t_mask[i]) begin
          n_fail++; $display("FAIL st32_bus[%0d.%0d] got req=%b we=%b wd=%h m=%b want 1/1/%h/%b",
                             i, d, a_mem_req, a_mem_we, a_mem_wdata, a_mem_wmask, t_expwd[i], t_mask[i]);
        end
        if (d == 2) a_mem_ack = 1'b1;
      end
      @(negedge clk);
      a_mem_ack = 1'b0;
      n_tests++; if (a_resp_valid !== 1'b1) begin
        n_fail++; $display("FAIL st32_resp[%0d] got resp_valid=%b want 1", i, a_resp_valid); end
      else begin
        e = sbq.pop_front();
        n_tests++; if ({32'd0, a_resp_rdata} !== e.rdata || a_except !== e.exc) begin
          n_fail++; $display("FAIL st32_data[%0d] got %h exc=%b want %h exc=%b",
                             i, a_resp_rdata, a_except, e.rdata, e.exc); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_except32();
    logic        t_we[4]    = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  t_size[4]  = '{2'd2, 2'd3, 2'd1, 2'd2};
    logic [31:0] t_addr[4]  = '{32'h06, 32'h00, 32'h01, 32'h02};
    logic [1:0]  t_cause[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      a_mem_ack = 1'b1;  // must be ignored: no bus cycle is issued
      issue_a(t_we[i], t_size[i], 1'b0, t_addr[i], 32'hFFFF_FFFF);
      sbq.push_back('{rdata: 64'd0, exc: 1'b1, cause: t_cause[i]});
      @(negedge clk);
      a_mem_ack = 1'b0;
      n_tests++; if (a_mem_req !== 1'b0 || a_resp_valid !== 1'b1) begin
        n_fail++; $display("FAIL exc32_path[%0d] got req=%b valid=%b want 0/1", i, a_mem_req, a_resp_valid); end
      if (a_resp_valid === 1'b1) begin
        e = sbq.pop_front();
        n_tests++;
        if ({32'd0, a_resp_rdata} !== e.rdata || a_except !== e.exc || a_except_cause !== e.cause) begin
          n_fail++; $display("FAIL exc32_cause[%0d] got rd=%h exc=%b cause=%b want %h/%b/%b",
                             i, a_resp_rdata, a_except, a_except_cause, e.rdata, e.exc, e.cause);
        end
      end
      @(negedge clk);
      n_tests++; if (a_req_ready !== 1'b1 || a_except !== 1'b0 || a_except_cause !== 2'b00) begin
        n_fail++; $display("FAIL exc32_idle[%0d] got ready=%b exc=%b cause=%b want 1/0/00",
                           i, a_req_ready, a_except, a_except_cause); end
    end
  endtask

  task automatic test_timeout();
    int   req_cycles = 0;
    logic seen = 1'b0;
    exp_t e;
    issue_a(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    sbq.push_back('{rdata: 64'd0, exc: 1'b1, cause: 2'b11});
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (a_mem_req === 1'b1) req_cycles++;
      if (a_resp_valid === 1'b1) seen = 1'b1;
    end
    n_tests++; if (!seen || req_cycles != 4) begin
      n_fail++; $display("FAIL timeout_len got seen=%b mem_req_cycles=%0d want 1/4", seen, req_cycles); end
    if (seen) begin
      e = sbq.pop_front();
      n_tests++;
      if ({32'd0, a_resp_rdata} !== e.rdata || a_except !== e.exc || a_except_cause !== e.cause) begin
        n_fail++; $display("FAIL timeout_cause got rd=%h exc=%b cause=%b want %h/%b/%b",
                           a_resp_rdata, a_except, a_except_cause, e.rdata, e.exc, e.cause);
      end
    end else begin
      void'(sbq.pop_front());
    end
    @(negedge clk);
    n_tests++; if (a_req_ready !== 1'b1 || a_mem_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_idle got ready=%b req=%b want 1/0", a_req_ready, a_mem_req); end
  endtask

  task automatic test_load64();
    logic [1:0]  t_size[4]  = '{2'd2, 2'd3, 2'd1, 2'd2};
    logic        t_uext[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [63:0] t_addr[4]  = '{64'h4C, 64'h10, 64'h06, 64'h00};
    logic [63:0] t_mrd[4]   = '{64'h9ABC_DEF0_1234_5678, 64'h8123_4567_89AB_CDEF,
                                64'h8001_0000_0000_0000, 64'h0000_0000_8000_0001};
    logic [63:0] t_maddr[4] = '{64'h48, 64'h10, 64'h00, 64'h00};
    logic [7:0]  t_mask[4]  = '{8'hF0, 8'hFF, 8'hC0, 8'h0F};
    logic [63:0] t_exp[4]   = '{64'h0000_0000_9ABC_DEF0, 64'h8123_4567_89AB_CDEF,
                                64'hFFFF_FFFF_FFFF_8001, 64'hFFFF_FFFF_8000_0001};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue_b(1'b0, t_size[i], t_uext[i], t_addr[i], 64'h0);
      sbq.push_back('{rdata: t_exp[i], exc: 1'b0, cause: 2'b00});
      @(negedge clk);
      n_tests++; if (b_mem_req !== 1'b1 || b_mem_addr !== t_maddr[i] || b_mem_wmask !== t_mask[i]) begin
        n_fail++; $display("FAIL ld64_bus[%0d] got req=%b addr=%h m=%h want 1/%h/%h",
                           i, b_mem_req, b_mem_addr, b_mem_wmask, t_maddr[i], t_mask[i]); end
      b_mem_ack = 1'b1; b_mem_rdata = t_mrd[i];
      @(negedge clk);
      b_mem_ack = 1'b0;
      n_tests++; if (b_resp_valid !== 1'b1) begin
        n_fail++; $display("FAIL ld64_latency[%0d] got resp_valid=%b want 1", i, b_resp_valid); end
      else begin
        e = sbq.pop_front();
        n_tests++; if (b_resp_rdata !== e.rdata || b_except !== e.exc) begin
          n_fail++; $display("FAIL ld64_data[%0d] got %h exc=%b want %h exc=%b",
                             i, b_resp_rdata, b_except, e.rdata, e.exc); end
      end
      @(negedge clk);
    end
    // Dword store at a word-aligned address is misaligned on the 64-bit bus.
    issue_b(1'b1, 2'd3, 1'b0, 64'h4, 64'h1);
    @(negedge clk);
    n_tests++; if (b_resp_valid !== 1'b1 || b_except !== 1'b1 || b_except_cause !== 2'b10 || b_mem_req !== 1'b0) begin
      n_fail++; $display("FAIL exc64 got valid=%b exc=%b cause=%b req=%b want 1/1/10/0",
                         b_resp_valid, b_except, b_except_cause, b_mem_req); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic stray = 1'b0;
    logic seen  = 1'b0;
    exp_t e;
    issue_a(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
    repeat (2) @(negedge clk);
    n_tests++; if (a_mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rmid_bus got mem_req=%b want 1", a_mem_req); end
    reset = 1'b1;
    #1;
    n_tests++; if (a_mem_req !== 1'b0 || a_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_async got req=%b ready=%b want 0/1", a_mem_req, a_req_ready); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (a_resp_valid !== 1'b0 || a_mem_req !== 1'b0) stray = 1'b1;
    end
    n_tests++; if (stray || a_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_quiet got stray=%b ready=%b want 0/1", stray, a_req_ready); end
    // Fresh request with ack held off three cycles.
    issue_a(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
    sbq.push_back('{rdata: 64'h0000_0000_1122_3344, exc: 1'b0, cause: 2'b00});
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      if (d == 3) begin a_mem_ack = 1'b1; a_mem_rdata = 32'h1122_3344; end
    end
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      a_mem_ack = 1'b0;
      if (a_resp_valid === 1'b1) seen = 1'b1;
    end
    n_tests++; if (!seen) begin
      n_fail++; $display("FAIL rmid_resp got no resp_valid within bound want 1"); void'(sbq.pop_front()); end
    else begin
      e = sbq.pop_front();
      n_tests++; if ({32'd0, a_resp_rdata} !== e.rdata || a_except !== e.exc) begin
        n_fail++; $display("FAIL rmid_data got %h exc=%b want %h exc=%b", a_resp_rdata, a_except, e.rdata, e.exc); end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load32();
    test_store32();
    test_except32();
    test_timeout();
    test_load64();
    test_reset_mid();
    n_tests++; if (sbq.size() != 0) begin
      n_fail++; $display("FAIL sb_drain got %0d entries want 0", sbq.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_handshake.md
Name: lsu_handshake

Overview:
- Parametrised load/store unit sitting between the core datapath and the data memory bus. It replaces the direct combinational memory path with a registered valid/ready request–response interface.
- Supports XLEN 32 or 64: sub-word lane placement, byte masks, sign/zero extension, misalignment detection and bus-timeout detection.
- The memory side uses a req/ack handshake, so memories with wait states are supported.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- TIMEOUT, 16, cycles mem_req may stay unacknowledged before a bus-timeout exception; must be ≥2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  unit can accept a request
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when XLEN=64)
- req_uext  in  1  loads: 1=zero-extend, 0=sign-extend
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores and exceptions
- except  out  1  completion carries an exception
- except_cause  out  2  00 none, 01 misaligned/illegal load, 10 misaligned/illegal store, 11 bus timeout
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  bus write
- mem_addr  out  XLEN  word-aligned address (low log2(XLEN/8) bits = 0)
- mem_wmask  out  XLEN/8  byte-enable mask
- mem_wdata  out  XLEN  lane-shifted store data
- mem_ack  in  1  bus completes access this cycle
- mem_rdata  in  XLEN  read data, valid with mem_ack

Behaviour:
- All outputs are registered. On reset (asynchronous, active-high): state=IDLE, every output 0 except req_ready=1, timeout counter=0.
- Reset asserted mid-transaction abandons the access. mem_req drops immediately; no response is produced.
- FSM states are IDLE, BUS, RESP.
- IDLE: req_ready=1. A request is accepted on a clk edge with req_valid=1.
  - Let off = req_addr low bits (2 bits for XLEN=32, 3 bits for XLEN=64).
  - The access is misaligned if off is not a multiple of 2^req_size.
  - The access is illegal if req_size=11 and XLEN=32.
  - Misaligned or illegal -> RESP with except=1 and cause 01 (load) or 10 (store). No bus cycle is issued.
  - Otherwise -> BUS with these registered values:
    - mem_addr = req_addr with off cleared
    - mem_wmask = ((1<<2^req_size)-1) << off, for both loads and stores
    - mem_wdata = req_wdata << (8·off)
    - mem_we = req_we
    - counter cleared
- BUS: mem_req=1 and req_ready=0.
  - On an edge with mem_ack=1 -> RESP.
  - For loads, resp_rdata = extend((mem_rdata >> 8·off) truncated to 8·2^req_size bits, req_uext).
  - For stores, resp_rdata = 0.
  - Without ack, the counter increments each cycle. When it reaches TIMEOUT-1 -> RESP with except=1, cause=11; the access is abandoned.
  - The memory-side fields stay stable while mem_req=1.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata, except and except_cause are valid only while resp_valid=1 and are 0 otherwise.
- Minimum latency:
  - Accept at edge k, mem_req high during cycle k+1, ack sampled at edge k+1, resp_valid high during cycle k+2, req_ready high again from cycle k+3.
  - Exception path: resp_valid during cycle k+1.
- One outstanding access; there is no back-to-back overlap.
- mem_ack outside BUS is ignored.
- req_size=11 with XLEN=64: full-width access with no extension.
- Extension from a width equal to XLEN is identity.

Test Plan:
- XLEN=32, load byte addr 0x103, req_uext=0, mem_rdata=0x80FF_1234 acked in first BUS cycle -> mem_addr=0x100, mem_wmask=4'b1000, resp_rdata=0xFFFF_FF80, resp_valid 2 cycles after accept.
- XLEN=32, store half addr 0x22, req_wdata=0x0000_ABCD -> mem_wdata=0xABCD_0000, mem_wmask=4'b1100, mem_we=1, resp_valid after ack with except=0.
- XLEN=32, load word addr 0x06 -> no mem_req, resp_valid next cycle, except=1, cause=01; store dword -> cause=10.
- TIMEOUT=4, mem_ack held 0 -> mem_req high exactly 4 cycles, then resp_valid with cause=11, then req_ready=1.
- XLEN=64, load word addr 0x4C, req_uext=1, mem_rdata=0x9ABC_DEF0_1234_5678 -> mem_wmask=8'hF0, resp_rdata=0x0000_0000_9ABC_DEF0.
- Ack delayed 3 cycles, reset pulsed in BUS -> mem_req=0 immediately, no resp_valid, req_ready=1 after release, next request completes normally.
